// File: rtl/lock_seq_ctrl_if.sv
// lock_seq_ctrl_if: keypad/code inputs and status outputs of the combination lock sequencer.
// Signals:
//   strobe    key-held level from the key synchronizer
//   key       key code: 0-15 digit, 16 start/relock, 17 clear
//   code      stored combination, digit 0 in code[31:28], digit 7 in code[3:0]
//   state_o   IDLE=0 ENTRY=1 OPEN=2 LOCKOUT=3 ALARM=4
//   digit_idx index of the next digit expected
//   fails     consecutive failed attempts
//   timer     remaining LOCKOUT or entry-timeout cycles
//   unlock    high in OPEN
//   alarm     high in ALARM
// master drives the keypad side, slave is the lock controller.
interface lock_seq_ctrl_if;
    logic        strobe;
    logic [4:0]  key;
    logic [31:0] code;
    logic [2:0]  state_o;
    logic [2:0]  digit_idx;
    logic [1:0]  fails;
    logic [9:0]  timer;
    logic        unlock;
    logic        alarm;
    modport master (output strobe, key, code,
                    input  state_o, digit_idx, fails, timer, unlock, alarm);
    modport slave  (input  strobe, key, code,
                    output state_o, digit_idx, fails, timer, unlock, alarm);
endinterface

// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: 8-digit combination lock sequencer with lockout and permanent alarm.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  lock_seq_ctrl_if.slave (strobe/key/code in; state_o/digit_idx/fails/timer/unlock/alarm out)
// Parameters: MAX_FAILS (1..3), LOCKOUT_CYC (1..1023), TIMEOUT_CYC (1..1023).
// Optional feature: define ENTRY_TIMEOUT_EN to abort ENTRY after TIMEOUT_CYC idle cycles.
module lock_seq_ctrl #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int TIMEOUT_CYC = 500
) (
    input logic              clk,
    input logic              rst,
    lock_seq_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_LOCKOUT = 3'd3,
        S_ALARM   = 3'd4
    } state_t;

    if (MAX_FAILS < 1 || MAX_FAILS > 3 || LOCKOUT_CYC < 1 || LOCKOUT_CYC > 1023 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_cfg
        $error("lock_seq_ctrl: parameter out of legal range");
    end

    localparam logic [9:0] LOCK_T = 10'(LOCKOUT_CYC);
`ifdef ENTRY_TIMEOUT_EN
    localparam logic [9:0] ENTRY_T = 10'(TIMEOUT_CYC);
`else
    localparam logic [9:0] ENTRY_T = 10'd0;
`endif

    state_t      r_state, w_state_n;
    logic        r_strobe_q, r_mis, w_mis_n, r_unlock, r_alarm;
    logic [2:0]  r_idx, w_idx_n;
    logic [1:0]  r_fails, w_fails_n;
    logic [9:0]  r_timer, w_timer_n;
    logic        w_key_evt, w_digit, w_clear, w_miss, w_last_fail, w_fail, w_expire;
    logic [3:0]  w_nib;
    logic [9:0]  w_tick;

    assign w_key_evt   = bus.strobe & ~r_strobe_q;
    assign w_digit     = w_key_evt & ~bus.key[4];
    assign w_clear     = w_key_evt & (bus.key == 5'd17);
    // ~r_idx == 7 - r_idx, so the shift brings the nibble for r_idx down to bits [3:0]
    assign w_nib       = 4'(bus.code >> {~r_idx, 2'b00});
    assign w_miss      = r_mis | (bus.key[3:0] != w_nib);
    assign w_last_fail = ({1'b0, r_fails} + 3'd1) == 3'(MAX_FAILS);
`ifdef ENTRY_TIMEOUT_EN
    assign w_expire    = r_timer == 10'd1;
    assign w_tick      = r_timer - 10'd1;
`else
    assign w_expire    = 1'b0;
    assign w_tick      = 10'd0;
`endif

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_fails_n = r_fails;
        w_timer_n = r_timer;
        w_mis_n   = r_mis;
        w_fail    = 1'b0;
        case (r_state)
            S_IDLE: if (w_key_evt && bus.key == 5'd16) begin
                w_state_n = S_ENTRY;
                w_idx_n   = 3'd0;
                w_mis_n   = 1'b0;
                w_timer_n = ENTRY_T;
            end
            S_ENTRY: begin
                // timeout expiry wins over a key arriving in the same cycle
                if (w_expire) w_fail = 1'b1;
                else if (w_digit) begin
                    w_idx_n   = r_idx + 3'd1;
                    w_mis_n   = w_miss;
                    w_timer_n = ENTRY_T;
                    if (r_idx == 3'd7) begin
                        if (w_miss) w_fail = 1'b1;
                        else begin
                            w_state_n = S_OPEN;
                            w_fails_n = 2'd0;
                            w_idx_n   = 3'd0;
                            w_mis_n   = 1'b0;
                            w_timer_n = 10'd0;
                        end
                    end
                end
                else if (w_clear) begin
                    w_idx_n   = 3'd0;
                    w_mis_n   = 1'b0;
                    w_timer_n = ENTRY_T;
                end
                else w_timer_n = w_tick;
            end
            S_OPEN: if (w_key_evt && bus.key == 5'd16) w_state_n = S_IDLE;
            S_LOCKOUT: begin
                w_timer_n = r_timer - 10'd1;
                if (r_timer == 10'd1) w_state_n = S_IDLE;
            end
            S_ALARM: ;
            default: w_state_n = S_IDLE;
        endcase
        if (w_fail) begin
            w_idx_n   = 3'd0;
            w_mis_n   = 1'b0;
            w_state_n = w_last_fail ? S_ALARM : S_LOCKOUT;
            w_fails_n = w_last_fail ? 2'(MAX_FAILS) : r_fails + 2'd1;
            w_timer_n = w_last_fail ? 10'd0 : LOCK_T;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_fails    <= 2'd0;
            r_timer    <= 10'd0;
            r_mis      <= 1'b0;
            r_strobe_q <= 1'b0;
            r_unlock   <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_idx      <= w_idx_n;
            r_fails    <= w_fails_n;
            r_timer    <= w_timer_n;
            r_mis      <= w_mis_n;
            r_strobe_q <= bus.strobe;
            r_unlock   <= w_state_n == S_OPEN;
            r_alarm    <= w_state_n == S_ALARM;
        end
    end

    assign bus.state_o   = r_state;
    assign bus.digit_idx = r_idx;
    assign bus.fails     = r_fails;
    assign bus.timer     = r_timer;
    assign bus.unlock    = r_unlock;
    assign bus.alarm     = r_alarm;
endmodule

// File: doc/lock_seq_ctrl.md
LOCK_SEQ_CTRL -- requirements
Module: lock_seq_ctrl

Interface
REQ-001 SHALL have parameters: MAX_FAILS, 3, failed attempts before permanent alarm (legal 1..3).
REQ-002 SHALL have parameter: LOCKOUT_CYC, 1000, cycles spent in LOCKOUT after a failed attempt that is not the last allowed (legal 1..1023).
REQ-003 SHALL have parameter: TIMEOUT_CYC, 500, idle cycles allowed between digits in ENTRY (legal 1..1023).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  hz100 system clock
- rst  in  1  synchronous active-high reset
- strobe  in  1  key-held level from key synchronizer
- key  in  5  key code: 0-15 digit, 16 = start/relock, 17 = clear
- code  in  32  stored combination; digit 0 is code[31:28], digit 7 is code[3:0]
- state_o  out  3  IDLE=0, ENTRY=1, OPEN=2, LOCKOUT=3, ALARM=4
- digit_idx  out  3  index of the next digit expected
- fails  out  2  consecutive failed attempts
- timer  out  10  remaining LOCKOUT or timeout cycles
- unlock  out  1  high in OPEN
- alarm  out  1  high in ALARM

Function
REQ-006 SHALL form key_evt = strobe & ~strobe_q (registered rising edge), sampling key in the same cycle; a held key SHALL produce exactly one event.
REQ-007 SHALL apply every state and output change on the clock edge after the key_evt cycle (1-cycle latency); all outputs SHALL be registered.
REQ-008 IDLE: key 16 -> ENTRY, with digit_idx=0 and the mismatch flag cleared; all other keys SHALL be ignored.
REQ-009 ENTRY, digit key (0-15): compare against the code nibble at digit_idx; on a miss, set the sticky mismatch flag; increment digit_idx.
REQ-010 Mismatch SHALL NOT be revealed before the 8th digit: no state change and no output change other than digit_idx.
REQ-011 On the 8th digit (digit_idx==7), the decision SHALL include that digit:
- no mismatch -> OPEN, fails=0
- mismatch and fails+1 == MAX_FAILS -> ALARM, fails=MAX_FAILS
- otherwise -> LOCKOUT, fails+1, timer=LOCKOUT_CYC
REQ-012 ENTRY: key 17 SHALL reset digit_idx to 0 and clear the mismatch flag, with no failure counted; keys 16, 18 and 19 SHALL be ignored.
REQ-013 LOCKOUT: timer SHALL decrement every cycle; when timer==1, the next state SHALL be IDLE with timer=0; all key events SHALL be ignored.
REQ-014 OPEN: key 16 -> IDLE (relock); all other keys SHALL be ignored.
REQ-015 ALARM SHALL be absorbing: only rst exits it.
REQ-016 digit_idx SHALL NOT wrap inside ENTRY; it is reset to 0 whenever ENTRY exits.
REQ-017 The code input SHALL be read only at comparison time; a code change mid-entry affects only the remaining digits.
REQ-018 If key_evt and a timer expiry occur in the same cycle, the expiry transition SHALL take priority and the key event SHALL be dropped.

Reset
REQ-019 rst SHALL force the following on the next edge, regardless of state, including mid-entry and ALARM:
- state_o=IDLE, digit_idx=0, fails=0, timer=0
- unlock=0, alarm=0
- strobe_q=0, mismatch flag cleared

Configuration
REQ-020 With ENTRY_TIMEOUT_EN defined:
- in ENTRY, timer SHALL load TIMEOUT_CYC on entry and on each accepted key
- timer SHALL decrement otherwise
- expiry SHALL count as a failed attempt per REQ-011's mismatch rules
REQ-021 Without ENTRY_TIMEOUT_EN, ENTRY SHALL have no timeout and timer SHALL read 0 in ENTRY.

Verification
REQ-022 Correct code: code=32'h1234_5678; key 16, then 1,2,3,4,5,6,7,8 -> state_o=OPEN, unlock=1, fails=0 one cycle after the 8th event.
REQ-023 Failure then lockout: wrong 3rd digit -> state stays ENTRY until the 8th digit, then LOCKOUT, fails=1, timer=1000, IDLE exactly 1000 cycles later.
REQ-024 Alarm: three wrong full entries -> ALARM, alarm=1, fails=3; keys ignored afterwards; rst -> IDLE, all outputs 0.
REQ-025 Clear and held key: key 17 after 5 digits -> digit_idx=0; strobe held 50 cycles -> exactly one digit accepted.
REQ-026 With ENTRY_TIMEOUT_EN and TIMEOUT_CYC=500: key 16, one digit, then 500 idle cycles -> LOCKOUT, fails=1.
REQ-027 Reset mid-operation: assert rst in ENTRY at digit_idx=4 -> IDLE, digit_idx=0 on the next edge.
